// File: rtl/sdf_pkg.sv
// Shared types and float helpers for the SDF scene combiner.
// Distances are 27-bit floats: sign[26], exp[25:18] (bias 127), mantissa[17:0].
// An exponent of 0 means zero, whatever the sign or mantissa bits hold.
package sdf_pkg;

   localparam int WIDTH = 27;

   typedef logic [WIDTH-1:0] sdf_word_t;

   typedef enum logic [1:0] {
      UNION     = 2'b00,
      INTERSECT = 2'b01,
      DIFF      = 2'b10,
      BYPASS    = 2'b11
   } sdf_op_t;

   function automatic logic f_is_zero(input sdf_word_t a);
      return (a[25:18] == 8'd0);
   endfunction

   // Maps a float onto an unsigned key with the same ordering. Zero of either
   // sign sits in the middle. Negatives go below it with their magnitude
   // inverted, so a larger magnitude gives a smaller key.
   function automatic sdf_word_t f_key(input sdf_word_t a);
      if (f_is_zero(a))
         return {1'b1, 26'd0};
      else if (a[26])
         return {1'b0, ~a[25:0]};
      else
         return {1'b1, a[25:0]};
   endfunction

   function automatic logic f_lt(input sdf_word_t a, input sdf_word_t b);
      return (f_key(a) < f_key(b));
   endfunction

   function automatic sdf_word_t f_neg(input sdf_word_t a);
      return {~a[26], a[25:0]};
   endfunction

   // On a tie both helpers return the first argument.
   function automatic sdf_word_t f_min(input sdf_word_t a, input sdf_word_t b);
      return f_lt(b, a) ? b : a;
   endfunction

   function automatic sdf_word_t f_max(input sdf_word_t a, input sdf_word_t b);
      return f_lt(a, b) ? b : a;
   endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Fixed-depth register delay line for one data word and its valid bit.
// A depth of 0 is a plain wire.
// Ports: clk, reset (sync, active high), i_d/i_v in, o_d/o_v out DEPTH cycles later.
module sdf_delay_line #(
   parameter int WIDTH = 27,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_d,
   input  logic             i_v,
   output logic [WIDTH-1:0] o_d,
   output logic             o_v
);

   if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk | reset;
      assign o_d = i_d;
      assign o_v = i_v;
   end else begin : g_regs
      logic [WIDTH-1:0] d_q [DEPTH];
      logic [DEPTH-1:0] v_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
            v_q <= '0;
         end else begin
            d_q[0] <= i_d;
            v_q[0] <= i_v;
            for (int i = 1; i < DEPTH; i++) begin
               d_q[i] <= d_q[i-1];
               v_q[i] <= v_q[i-1];
            end
         end
      end

      assign o_d = d_q[DEPTH-1];
      assign o_v = v_q[DEPTH-1];
   end

endmodule

// File: rtl/sdf_combine_n.sv
// N-channel SDF scene combiner. Re-aligns channels whose primitive pipelines
// have different latencies, then folds them through a registered chain of
// runtime-selectable CSG operators.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_valid           point issued into the primitive pipelines this cycle
//   i_dist            channel k distance at [k*WIDTH +: WIDTH], valid LAT_k after i_valid
//   cfg_we, cfg_ops   operator register write; stage j op at [2j +: 2]
//   o_dist, o_id      combined distance and the channel that produced it
//   o_valid           o_dist/o_id valid, LAT_MAX+NUM_SDF-1 cycles after i_valid
module sdf_combine_n #(
   parameter int WIDTH   = 27,
   parameter int NUM_SDF = 4,
   parameter int LAT_W   = 5,
   parameter logic [NUM_SDF*LAT_W-1:0] SDF_LAT = {NUM_SDF{LAT_W'(16)}},
   parameter int LAT_MAX = 16,
   localparam int ID_W   = $clog2(NUM_SDF),
   localparam int OPS_W  = 2*(NUM_SDF-1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_valid,
   input  logic [NUM_SDF*WIDTH-1:0] i_dist,
   input  logic                     cfg_we,
   input  logic [OPS_W-1:0]         cfg_ops,
   output logic [WIDTH-1:0]         o_dist,
   output logic [ID_W-1:0]          o_id,
   output logic                     o_valid
);

   import sdf_pkg::*;

   localparam int NST = NUM_SDF - 1;

   function automatic int f_lat(input int k);
      return int'(SDF_LAT[k*LAT_W +: LAT_W]);
   endfunction

   function automatic int f_lat_max();
      int m;
      m = 0;
      for (int k = 0; k < NUM_SDF; k++)
         if (f_lat(k) > m) m = f_lat(k);
      return m;
   endfunction

   localparam int LAT_SEEN = f_lat_max();

   if (LAT_SEEN != LAT_MAX) begin : g_bad_lat
      $error("sdf_combine_n: LAT_MAX must equal the largest SDF_LAT field");
   end
   if (WIDTH != sdf_pkg::WIDTH) begin : g_bad_width
      $error("sdf_combine_n: WIDTH must match the 27-bit float format");
   end
   if (NUM_SDF < 2 || NUM_SDF > 8) begin : g_bad_num
      $error("sdf_combine_n: NUM_SDF must be 2..8");
   end

   // Alignment. Channel k>0 is consumed by fold stage k, which sees a sample
   // k-1 cycles after channel 0 is taken, so those channels carry k-1 extra
   // cycles of skew on top of the LAT_MAX - LAT_k alignment.
   logic [WIDTH-1:0]   ch_d [NUM_SDF];
   logic [NUM_SDF-1:0] ch_v_unused;
   logic               v0;
   logic               v0_d_unused;

   for (genvar k = 0; k < NUM_SDF; k++) begin : g_ch
      localparam int DEPTH = LAT_MAX - f_lat(k) + ((k == 0) ? 0 : k - 1);
      sdf_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dly (
         .clk   (clk),
         .reset (reset),
         .i_d   (i_dist[k*WIDTH +: WIDTH]),
         .i_v   (1'b0),
         .o_d   (ch_d[k]),
         .o_v   (ch_v_unused[k])
      );
   end

   sdf_delay_line #(.WIDTH(1), .DEPTH(LAT_MAX)) u_vdly (
      .clk   (clk),
      .reset (reset),
      .i_d   (1'b0),
      .i_v   (i_valid),
      .o_d   (v0_d_unused),
      .o_v   (v0)
   );

   logic [OPS_W-1:0] ops_q;

   always_ff @(posedge clk) begin
      if (reset)       ops_q <= '0;
      else if (cfg_we) ops_q <= cfg_ops;
   end

   // Stage 0 is channel 0 itself with id 0; the op register is snapshotted
   // when v0 enters the first registered stage and rides along with the sample.
   logic [WIDTH-1:0] in_d   [NST];
   logic [ID_W-1:0]  in_id  [NST];
   logic             in_v   [NST];
   logic [OPS_W-1:0] in_ops [NST];
   logic [WIDTH-1:0] nx_d   [NST];
   logic [ID_W-1:0]  nx_id  [NST];
   logic [WIDTH-1:0] st_d   [NST];
   logic [ID_W-1:0]  st_id  [NST];
   logic             st_v   [NST];
   logic [OPS_W-1:0] st_ops [NST];

   always_comb begin
      in_d[0]   = ch_d[0];
      in_id[0]  = '0;
      in_v[0]   = v0;
      in_ops[0] = ops_q;
      for (int s = 1; s < NST; s++) begin
         in_d[s]   = st_d[s-1];
         in_id[s]  = st_id[s-1];
         in_v[s]   = st_v[s-1];
         in_ops[s] = st_ops[s-1];
      end
      for (int s = 0; s < NST; s++) begin
         sdf_op_t   op;
         sdf_word_t b;
         sdf_word_t nb;
         op       = sdf_op_t'(in_ops[s][2*s +: 2]);
         b        = ch_d[s+1];
         nb       = f_neg(b);
         nx_d[s]  = in_d[s];
         nx_id[s] = in_id[s];
         case (op)
            UNION: begin
               if (f_lt(b, in_d[s])) begin
                  nx_d[s]  = b;
                  nx_id[s] = ID_W'(s + 1);
               end
            end
            INTERSECT: begin
               if (f_lt(in_d[s], b)) begin
                  nx_d[s]  = b;
                  nx_id[s] = ID_W'(s + 1);
               end
            end
            DIFF: begin
               if (f_lt(in_d[s], nb)) begin
                  nx_d[s]  = nb;
                  nx_id[s] = ID_W'(s + 1);
               end
            end
            default: ;
         endcase
      end
   end

   // Data only loads with a valid sample so the output holds between results.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < NST; s++) begin
            st_v[s]   <= 1'b0;
            st_d[s]   <= '0;
            st_id[s]  <= '0;
            st_ops[s] <= '0;
         end
      end else begin
         for (int s = 0; s < NST; s++) begin
            st_v[s] <= in_v[s];
            if (in_v[s]) begin
               st_d[s]   <= nx_d[s];
               st_id[s]  <= nx_id[s];
               st_ops[s] <= in_ops[s];
            end
         end
      end
   end

   assign o_dist  = st_d[NST-1];
   assign o_id    = st_id[NST-1];
   assign o_valid = st_v[NST-1];

endmodule

// File: tb/tb_sdf_combine_n.sv
// Directed bench for sdf_combine_n: 3 channels, latencies {ch2,ch1,ch0}={0,5,2},
// so a result appears 7 cycles after i_valid.
module tb_sdf_combine_n;

   localparam int W = 27;
   localparam logic [W-1:0] JUNK = 27'h3ffffff;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           i_valid = 1'b0;
   logic [3*W-1:0] i_dist = {3{JUNK}};
   logic           cfg_we = 1'b0;
   logic [3:0]     cfg_ops = 4'b0000;
   logic [W-1:0]   o_dist;
   logic [1:0]     o_id;
   logic           o_valid;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] s0 [32];
   logic [W-1:0] s1 [32];
   logic [W-1:0] s2 [32];
   logic [W-1:0] ed [32];
   logic [1:0]   eid [32];
   int           n_smp;
   int           we_cyc;
   logic [3:0]   we_val;

   sdf_combine_n #(
      .WIDTH   (W),
      .NUM_SDF (3),
      .LAT_W   (5),
      .SDF_LAT ({5'd0, 5'd5, 5'd2}),
      .LAT_MAX (5)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .i_valid (i_valid),
      .i_dist  (i_dist),
      .cfg_we  (cfg_we),
      .cfg_ops (cfg_ops),
      .o_dist  (o_dist),
      .o_id    (o_id),
      .o_valid (o_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic set_ops(input logic [3:0] v);
      cfg_we  = 1'b1;
      cfg_ops = v;
      @(posedge clk);
      #1;
      cfg_we  = 1'b0;
   endtask

   task automatic one(input logic [W-1:0] a0, input logic [W-1:0] a1,
                      input logic [W-1:0] a2, input logic [W-1:0] ex,
                      input logic [1:0] exid);
      s0[0] = a0; s1[0] = a1; s2[0] = a2; ed[0] = ex; eid[0] = exid;
      n_smp = 1;
      we_cyc = -1;
   endtask

   // Drives n_smp samples back to back, each channel at its own latency,
   // and checks o_valid every cycle plus data on valid and hold afterwards.
   task automatic run_seq(input string name);
      for (int c = 0; c < n_smp + 9; c++) begin
         logic ev;
         i_valid = (c < n_smp);
         i_dist[0 +: W]   = (c >= 2 && c - 2 < n_smp) ? s0[c-2] : JUNK;
         i_dist[W +: W]   = (c >= 5 && c - 5 < n_smp) ? s1[c-5] : JUNK;
         i_dist[2*W +: W] = (c < n_smp) ? s2[c] : JUNK;
         cfg_we = (c == we_cyc);
         if (c == we_cyc) cfg_ops = we_val;
         @(negedge clk);
         ev = (c >= 7 && c < 7 + n_smp);
         check($sformatf("%s_valid_c%0d", name, c), 32'(o_valid), 32'(ev));
         if (ev) begin
            check($sformatf("%s_dist[%0d]", name, c - 7), 32'(o_dist), 32'(ed[c-7]));
            check($sformatf("%s_id[%0d]", name, c - 7), 32'(o_id), 32'(eid[c-7]));
         end else if (c >= 7 + n_smp) begin
            check($sformatf("%s_hold_c%0d", name, c), 32'(o_dist), 32'(ed[n_smp-1]));
         end
         @(posedge clk);
         #1;
      end
      i_valid = 1'b0;
      cfg_we  = 1'b0;
      i_dist  = {3{JUNK}};
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_dist", 32'(o_dist), 32'd0);
      check("rst_id", 32'(o_id), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // union of 1.0, 2.0, 0.5 -> 0.5 from ch2
      one(27'h1fc0000, 27'h2000000, 27'h1f80000, 27'h1f80000, 2'd2);
      run_seq("t1");

      // stage1 diff: max(1.0, +0.5) keeps ch0; stage2 bypass
      set_ops(4'b1110);
      one(27'h1fc0000, 27'h5f80000, 27'h2000000, 27'h1fc0000, 2'd0);
      run_seq("t2");

      // +0 vs -0 tie keeps acc
      set_ops(4'b0000);
      one(27'h0000000, 27'h4000000, 27'h1fc0000, 27'h0000000, 2'd0);
      run_seq("t3");

      // intersect with mixed signs: max(-1.0, 0.5, -2.0) = 0.5 from ch1
      set_ops(4'b0101);
      one(27'h5fc0000, 27'h1f80000, 27'h6000000, 27'h1f80000, 2'd1);
      run_seq("t6");

      // diff picks -(-2.0)=2.0 from ch1, then union with 1.5 -> ch2
      set_ops(4'b0010);
      one(27'h1fc0000, 27'h6000000, 27'h1fe0000, 27'h1fe0000, 2'd2);
      run_seq("t7");

      // 20-sample burst; channel of rank r in sample i has exponent 100+i+10r,
      // rank r = (k-i) mod 3. Union picks rank 0, intersect picks rank 2.
      set_ops(4'b0000);
      n_smp  = 20;
      we_cyc = 12;
      we_val = 4'b0101;
      for (int i = 0; i < 20; i++) begin
         s0[i] = {1'b0, 8'(100 + i + 10 * ((0 + 21 - i) % 3)), 18'(i)};
         s1[i] = {1'b0, 8'(100 + i + 10 * ((1 + 21 - i) % 3)), 18'(i)};
         s2[i] = {1'b0, 8'(100 + i + 10 * ((2 + 21 - i) % 3)), 18'(i)};
         if (i <= 7) begin
            ed[i]  = {1'b0, 8'(100 + i), 18'(i)};
            eid[i] = 2'(i % 3);
         end else begin
            ed[i]  = {1'b0, 8'(120 + i), 18'(i)};
            eid[i] = 2'((i + 2) % 3);
         end
      end
      run_seq("t4");

      // reset 3 cycles into a sample: no result, ops back to union
      for (int c = 0; c < 16; c++) begin
         i_valid = (c == 0);
         i_dist[0 +: W]   = (c == 2) ? 27'h1fc0000 : JUNK;
         i_dist[W +: W]   = (c == 5) ? 27'h2000000 : JUNK;
         i_dist[2*W +: W] = (c == 0) ? 27'h1f80000 : JUNK;
         reset = (c == 3 || c == 4);
         @(negedge clk);
         check($sformatf("t5_valid_c%0d", c), 32'(o_valid), 32'd0);
         if (c == 5) begin
            check("t5_rst_dist", 32'(o_dist), 32'd0);
            check("t5_rst_id", 32'(o_id), 32'd0);
         end
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      one(27'h1fc0000, 27'h2000000, 27'h1f80000, 27'h1f80000, 2'd2);
      run_seq("t5");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
